pll_phase_stepper: RTL and testbench

Runtime dynamic-phase controller for the core's altera_pll instances, generalising the fixed compile-time SDRAM clock phase offset into a host-tunable one. It accepts relative or absolute phase commands for any of NUM_CNT PLL output counters and drives the PLL dynamic-phase-shift port (phase_en/updn/cntsel/phase_done) one VCO step at a time. It keeps a per-counter signed position register so firmware can sweep and centre the SDRAM capture window. It sits in the PLL's scan-clock domain, between the bridge register block and the PLL.

---
 rtl/pll_phase_pkg.sv | 17 +
 rtl/pll_phase_stepper_if.sv | 26 ++
 rtl/pll_phase_pos_bank.sv | 61 ++++++
 rtl/pll_phase_stepper.sv | 227 ++++++++++++++++++++++
 tb/tb_pll_phase_stepper.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_phase_pkg.sv
// Shared state encoding and width helper for the PLL dynamic-phase stepper.
package pll_phase_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_EN      = 3'd1,
      ST_WAIT_LO = 3'd2,
      ST_WAIT_HI = 3'd3,
      ST_SETTLE  = 3'd4
   } state_t;

   // clog2 with a floor of one bit, for index and counter widths.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pll_phase_stepper_if.sv
// Host command channel of the phase stepper: request/accept plus completion pulse.
interface pll_phase_stepper_if
   import pll_phase_pkg::*;
#(
   parameter int NUM_CNT = 5,
   parameter int POS_W   = 10
);
   localparam int SEL_W = idx_w(NUM_CNT);

   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_abs;
   logic [SEL_W-1:0] cmd_sel;
   logic [POS_W-1:0] cmd_value;
   logic             cmd_done;

   modport master (
      output cmd_valid, cmd_abs, cmd_sel, cmd_value,
      input  cmd_ready, cmd_done
   );

   modport slave (
      input  cmd_valid, cmd_abs, cmd_sel, cmd_value,
      output cmd_ready, cmd_done
   );
endinterface

// File: rtl/pll_phase_pos_bank.sv
// Per-counter signed phase positions: single-step update, clear-all,
// a combinational peek for absolute commands and a registered readback port.
module pll_phase_pos_bank
   import pll_phase_pkg::*;
#(
   parameter int  NUM_CNT = 5,
   parameter int  POS_W   = 10,
   localparam int SEL_W   = idx_w(NUM_CNT)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr_all,
   input  logic             inc,
   input  logic             dec,
   input  logic [SEL_W-1:0] step_sel,
   input  logic [SEL_W-1:0] peek_sel,
   output logic [POS_W-1:0] peek_data,
   input  logic [SEL_W-1:0] rd_sel,
   output logic [POS_W-1:0] rd_data
);
   logic [NUM_CNT-1:0][POS_W-1:0] pos_all;
   logic [POS_W-1:0]              rd_next;

   generate
      for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_pos
         logic [POS_W-1:0] pos_reg;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               pos_reg <= '0;
            end else if (clr_all) begin
               pos_reg <= '0;
            end else if (step_sel == SEL_W'(gi)) begin
               if (inc) begin
                  pos_reg <= pos_reg + POS_W'(1);
               end else if (dec) begin
                  pos_reg <= pos_reg - POS_W'(1);
               end
            end
         end
         assign pos_all[gi] = pos_reg;
      end
   endgenerate

   // Out-of-range indices fall through both muxes and read as zero.
   always_comb begin
      peek_data = '0;
      rd_next   = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
         if (peek_sel == SEL_W'(i)) peek_data = pos_all[i];
         if (rd_sel == SEL_W'(i))   rd_next   = pos_all[i];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data <= '0;
      end else begin
         rd_data <= rd_next;
      end
   end
endmodule

// File: rtl/pll_phase_stepper.sv
// Runtime PLL dynamic-phase controller: turns relative/absolute host commands into
// single VCO steps on phase_en/updn/cntsel and tracks a signed position per counter.
module pll_phase_stepper
   import pll_phase_pkg::*;
#(
   parameter int  NUM_CNT       = 5,
   parameter int  CNTSEL_W      = 5,
   parameter int  POS_W         = 10,
   parameter int  PHASE_EN_HOLD = 2,
   parameter int  DONE_TIMEOUT  = 1024,
   parameter int  SETTLE_CYCLES = 16,
   localparam int SEL_W         = idx_w(NUM_CNT)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                pll_locked,
   pll_phase_stepper_if.slave  cmd,
   output logic                busy,
   output logic                err_timeout,
   output logic                err_badsel,
   input  logic                err_clr,
   input  logic [SEL_W-1:0]    pos_rd_sel,
   output logic [POS_W-1:0]    pos_rd_data,
   output logic                phase_en,
   output logic                updn,
   output logic [CNTSEL_W-1:0] pll_cntsel,
   input  logic                phase_done
);
   localparam int HOLD_W = idx_w(PHASE_EN_HOLD);
   localparam int TO_W   = idx_w(DONE_TIMEOUT);
   localparam int SET_W  = idx_w(SETTLE_CYCLES);
   localparam logic [POS_W:0] REM_ONE = (POS_W+1)'(1);

   state_t              state_reg, state_next;
   logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
   logic [TO_W-1:0]     to_cnt_reg, to_cnt_next;
   logic [SET_W-1:0]    settle_cnt_reg, settle_cnt_next;
   logic [POS_W:0]      rem_reg, rem_next;
   logic                seen_lo_reg, seen_lo_next;
   logic [SEL_W-1:0]    sel_reg;
   logic                updn_reg, phase_en_reg, busy_reg, done_reg;
   logic                err_to_reg, err_bs_reg, run_reg;
   logic [CNTSEL_W-1:0] cntsel_reg;

   logic                done_next, step_inc, step_dec, pos_clr;
   logic                badsel_set, timeout_set, load_cmd, sel_ok;
   logic [POS_W-1:0]    peek_data;
   logic signed [POS_W:0] cmd_ext, pos_ext, delta;
   logic [POS_W:0]      delta_mag;

   // Delta is formed one bit wider than a position so absolute targets never wrap.
   assign sel_ok    = (32'(cmd.cmd_sel) < NUM_CNT);
   assign cmd_ext   = {cmd.cmd_value[POS_W-1], cmd.cmd_value};
   assign pos_ext   = {peek_data[POS_W-1], peek_data};
   assign delta     = cmd.cmd_abs ? (cmd_ext - pos_ext) : cmd_ext;
   assign delta_mag = delta[POS_W] ? $unsigned(-delta) : $unsigned(delta);

   pll_phase_pos_bank #(.NUM_CNT(NUM_CNT), .POS_W(POS_W)) u_pos_bank (
      .clk       (clk),
      .reset_n   (reset_n),
      .clr_all   (pos_clr),
      .inc       (step_inc),
      .dec       (step_dec),
      .step_sel  (sel_reg),
      .peek_sel  (cmd.cmd_sel),
      .peek_data (peek_data),
      .rd_sel    (pos_rd_sel),
      .rd_data   (pos_rd_data)
   );

   always_comb begin
      state_next      = state_reg;
      hold_cnt_next   = hold_cnt_reg;
      to_cnt_next     = to_cnt_reg;
      settle_cnt_next = settle_cnt_reg;
      rem_next        = rem_reg;
      seen_lo_next    = seen_lo_reg;
      done_next       = 1'b0;
      step_inc        = 1'b0;
      step_dec        = 1'b0;
      pos_clr         = 1'b0;
      badsel_set      = 1'b0;
      timeout_set     = 1'b0;
      load_cmd        = 1'b0;

      if (!pll_locked) begin
         // Lock loss means the PLL reloads its compile-time phases.
         state_next = ST_IDLE;
         pos_clr    = 1'b1;
         done_next  = (state_reg != ST_IDLE);
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (cmd.cmd_valid && run_reg) begin
                  if (!sel_ok) begin
                     badsel_set = 1'b1;
                     done_next  = 1'b1;
                  end else if (delta == '0) begin
                     done_next = 1'b1;
                  end else begin
                     load_cmd      = 1'b1;
                     rem_next      = delta_mag;
                     state_next    = ST_EN;
                     hold_cnt_next = '0;
                     to_cnt_next   = '0;
                     seen_lo_next  = 1'b0;
                  end
               end
            end
            ST_EN: begin
               to_cnt_next = to_cnt_reg + TO_W'(1);
               if (!phase_done) seen_lo_next = 1'b1;
               if (to_cnt_reg == TO_W'(DONE_TIMEOUT - 1)) begin
                  timeout_set = 1'b1;
                  done_next   = 1'b1;
                  state_next  = ST_IDLE;
               end else if (hold_cnt_reg == HOLD_W'(PHASE_EN_HOLD - 1)) begin
                  state_next = (seen_lo_reg || !phase_done) ? ST_WAIT_HI : ST_WAIT_LO;
               end else begin
                  hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
               end
            end
            ST_WAIT_LO: begin
               to_cnt_next = to_cnt_reg + TO_W'(1);
               if (to_cnt_reg == TO_W'(DONE_TIMEOUT - 1)) begin
                  timeout_set = 1'b1;
                  done_next   = 1'b1;
                  state_next  = ST_IDLE;
               end else if (!phase_done) begin
                  state_next = ST_WAIT_HI;
               end
            end
            ST_WAIT_HI: begin
               to_cnt_next = to_cnt_reg + TO_W'(1);
               if (phase_done) begin
                  step_inc = updn_reg;
                  step_dec = !updn_reg;
                  rem_next = rem_reg - REM_ONE;
                  if (SETTLE_CYCLES != 0) begin
                     state_next      = ST_SETTLE;
                     settle_cnt_next = '0;
                  end else if (rem_reg == REM_ONE) begin
                     state_next = ST_IDLE;
                     done_next  = 1'b1;
                  end else begin
                     state_next    = ST_EN;
                     hold_cnt_next = '0;
                     to_cnt_next   = '0;
                     seen_lo_next  = 1'b0;
                  end
               end else if (to_cnt_reg == TO_W'(DONE_TIMEOUT - 1)) begin
                  timeout_set = 1'b1;
                  done_next   = 1'b1;
                  state_next  = ST_IDLE;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt_reg == SET_W'(SETTLE_CYCLES - 1)) begin
                  if (rem_reg == '0) begin
                     state_next = ST_IDLE;
                     done_next  = 1'b1;
                  end else begin
                     state_next    = ST_EN;
                     hold_cnt_next = '0;
                     to_cnt_next   = '0;
                     seen_lo_next  = 1'b0;
                  end
               end else begin
                  settle_cnt_next = settle_cnt_reg + SET_W'(1);
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= ST_IDLE;
         hold_cnt_reg   <= '0;
         to_cnt_reg     <= '0;
         settle_cnt_reg <= '0;
         rem_reg        <= '0;
         seen_lo_reg    <= 1'b0;
         sel_reg        <= '0;
         updn_reg       <= 1'b0;
         cntsel_reg     <= '0;
         phase_en_reg   <= 1'b0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         err_to_reg     <= 1'b0;
         err_bs_reg     <= 1'b0;
         run_reg        <= 1'b0;
      end else begin
         state_reg      <= state_next;
         hold_cnt_reg   <= hold_cnt_next;
         to_cnt_reg     <= to_cnt_next;
         settle_cnt_reg <= settle_cnt_next;
         rem_reg        <= rem_next;
         seen_lo_reg    <= seen_lo_next;
         run_reg        <= 1'b1;
         phase_en_reg   <= (state_next == ST_EN);
         busy_reg       <= (state_next != ST_IDLE);
         done_reg       <= done_next;
         if (load_cmd) begin
            sel_reg    <= cmd.cmd_sel;
            updn_reg   <= !delta[POS_W];
            cntsel_reg <= CNTSEL_W'(cmd.cmd_sel);
         end
         // A set in the same cycle as err_clr wins.
         if (timeout_set)  err_to_reg <= 1'b1;
         else if (err_clr) err_to_reg <= 1'b0;
         if (badsel_set)   err_bs_reg <= 1'b1;
         else if (err_clr) err_bs_reg <= 1'b0;
      end
   end

   // run_reg keeps cmd_ready low while reset is held, whatever pll_locked does.
   assign cmd.cmd_ready = (state_reg == ST_IDLE) && pll_locked && run_reg;
   assign cmd.cmd_done  = done_reg;
   assign busy          = busy_reg;
   assign err_timeout   = err_to_reg;
   assign err_badsel    = err_bs_reg;
   assign phase_en      = phase_en_reg;
   assign updn          = updn_reg;
   assign pll_cntsel    = cntsel_reg;
endmodule

// File: tb/tb_pll_phase_stepper.sv
// Self-checking bench for pll_phase_stepper: directed plan plus random commands
// against a per-counter position model and a simple PLL phase_done responder.
module tb_pll_phase_stepper;
   localparam int NUM_CNT  = 5;
   localparam int POS_W    = 10;
   localparam int CNTSEL_W = 5;
   localparam int HOLD     = 2;
   localparam int TO       = 1024;

   logic                clk = 1'b0;
   logic                reset_n = 1'b0;
   logic                pll_locked = 1'b1;
   logic                err_clr = 1'b0;
   logic [2:0]          pos_rd_sel = '0;
   logic                busy, err_timeout, err_badsel, phase_en, updn, phase_done;
   logic [POS_W-1:0]    pos_rd_data;
   logic [CNTSEL_W-1:0] pll_cntsel;

   pll_phase_stepper_if #(.NUM_CNT(NUM_CNT), .POS_W(POS_W)) cmd_if ();

   pll_phase_stepper #(
      .NUM_CNT(NUM_CNT), .CNTSEL_W(CNTSEL_W), .POS_W(POS_W),
      .PHASE_EN_HOLD(HOLD), .DONE_TIMEOUT(TO), .SETTLE_CYCLES(16)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .pll_locked  (pll_locked),
      .cmd         (cmd_if.slave),
      .busy        (busy),
      .err_timeout (err_timeout),
      .err_badsel  (err_badsel),
      .err_clr     (err_clr),
      .pos_rd_sel  (pos_rd_sel),
      .pos_rd_data (pos_rd_data),
      .phase_en    (phase_en),
      .updn        (updn),
      .pll_cntsel  (pll_cntsel),
      .phase_done  (phase_done)
   );

   always #5 clk = ~clk;

   // PLL responder: phase_done drops one cycle after phase_en rises, stays low lo_cycles.
   int lo_cycles = 4;
   bit pll_stuck = 1'b0;
   initial begin
      phase_done = 1'b1;
      forever begin
         @(posedge phase_en);
         if (!pll_stuck) begin
            @(posedge clk);
            #1 phase_done = 1'b0;
            repeat (lo_cycles) @(posedge clk);
            #1 phase_done = 1'b1;
         end
      end
   end

   // Monitor: counts phase_en pulses, bad pulse widths, updn/cntsel glitches, cmd_done pulses.
   int   cyc = 0;
   int   en_rises = 0, en_len = 0, wid_bad = 0, sig_bad = 0, done_cnt = 0;
   int   last_rise_cyc = 0, to_rise_cyc = 0;
   logic prev_en = 1'b0, prev_to = 1'b0;
   logic exp_updn = 1'b0;
   logic [CNTSEL_W-1:0] exp_cntsel = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      prev_en <= phase_en;
      prev_to <= err_timeout;
      if (phase_en && !prev_en) begin
         en_rises      <= en_rises + 1;
         last_rise_cyc <= cyc;
      end
      if (phase_en) begin
         en_len <= en_len + 1;
         if (updn !== exp_updn || pll_cntsel !== exp_cntsel) sig_bad <= sig_bad + 1;
      end else if (en_len != 0) begin
         if (en_len != HOLD) wid_bad <= wid_bad + 1;
         en_len <= 0;
      end
      if (err_timeout && !prev_to) to_rise_cyc <= cyc;
      if (cmd_if.cmd_done) done_cnt <= done_cnt + 1;
   end

   int n_assert = 0;
   int n_fail   = 0;
   int model_pos [NUM_CNT];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic int wrap(input int x);
      int w;
      w = x & ((1 << POS_W) - 1);
      return (w >= (1 << (POS_W - 1))) ? w - (1 << POS_W) : w;
   endfunction

   function automatic logic [31:0] pos_bits(input int p);
      logic [31:0] v;
      v = 32'(p);
      return {22'd0, v[POS_W-1:0]};
   endfunction

   task automatic send(input bit a, input int s, input int v);
      int n = 0;
      while (cmd_if.cmd_ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk("cmd_ready_before_send", 32'(cmd_if.cmd_ready), 32'd1);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_abs   = a;
      cmd_if.cmd_sel   = 3'(s);
      cmd_if.cmd_value = POS_W'(v);
      @(posedge clk);
      #1;
      cmd_if.cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int base, input string tag);
      int n = 0;
      while (done_cnt == base && n < 3000) begin
         tick();
         n++;
      end
      chk({tag, "_done_seen"}, 32'(done_cnt != base), 32'd1);
   endtask

   task automatic read_pos(input int s, input string tag);
      logic [31:0] e;
      pos_rd_sel = 3'(s);
      tick();
      e = (s < NUM_CNT) ? pos_bits(model_pos[s]) : 32'd0;
      chk(tag, {22'd0, pos_rd_data}, e);
   endtask

   task automatic run_cmd(input bit a, input int s, input int v, input string tag);
      int delta, steps, b_r, b_w, b_s, b_d;
      bit bad;
      bad   = (s >= NUM_CNT);
      delta = bad ? 0 : (a ? v - model_pos[s] : v);
      steps = (delta < 0) ? -delta : delta;
      exp_updn   = (delta > 0);
      exp_cntsel = CNTSEL_W'(s);
      b_r = en_rises; b_w = wid_bad; b_s = sig_bad; b_d = done_cnt;
      send(a, s, v);
      if (steps == 0) chk({tag, "_done_next_cycle"}, 32'(cmd_if.cmd_done), 32'd1);
      wait_done(b_d, tag);
      repeat (3) tick();
      chk({tag, "_steps"}, 32'(en_rises - b_r), 32'(steps));
      chk({tag, "_en_width"}, 32'(wid_bad - b_w), 32'd0);
      chk({tag, "_updn_cntsel"}, 32'(sig_bad - b_s), 32'd0);
      chk({tag, "_done_pulses"}, 32'(done_cnt - b_d), 32'd1);
      chk({tag, "_badsel"}, 32'(err_badsel), 32'(bad));
      chk({tag, "_idle"}, {30'd0, busy, cmd_if.cmd_ready}, 32'd1);
      if (!bad) model_pos[s] = a ? v : wrap(model_pos[s] + v);
      read_pos(s, {tag, "_pos"});
      $display("cmd %s abs=%0d sel=%0d value=%0d steps=%0d pos=%0d", tag, a, s, v, steps,
               bad ? 0 : model_pos[s]);
   endtask

   initial begin
      int b_r, b_d, n;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_abs   = 1'b0;
      cmd_if.cmd_sel   = '0;
      cmd_if.cmd_value = '0;
      for (int i = 0; i < NUM_CNT; i++) model_pos[i] = 0;

      // Reset state
      tick();
      chk("reset_outputs", {24'd0, phase_en, updn, busy, cmd_if.cmd_done, cmd_if.cmd_ready,
                            err_timeout, err_badsel, 1'b0}, 32'd0);
      chk("reset_cntsel", 32'(pll_cntsel), 32'd0);
      chk("reset_rd", 32'(pos_rd_data), 32'd0);
      reset_n = 1'b1;
      tick(); tick();
      chk("ready_after_reset", 32'(cmd_if.cmd_ready), 32'd1);
      $display("reset released, cmd_ready=%0d", cmd_if.cmd_ready);

      // Plan items 1-2
      lo_cycles = 4;
      run_cmd(1'b0, 1, 3, "t1_rel_p3");
      run_cmd(1'b1, 1, -2, "t2_abs_m2");
      chk("t2_pos_raw", 32'(pos_rd_data), 32'h3FE);
      run_cmd(1'b1, 1, -2, "t2_abs_same");

      // Random commands against the model
      for (int k = 0; k < 10; k++) begin
         bit a;
         int s, v;
         a = 1'($urandom_range(0, 1));
         s = int'($urandom_range(0, NUM_CNT - 1));
         v = a ? int'($urandom_range(0, 10)) - 5 : int'($urandom_range(0, 8)) - 4;
         lo_cycles = int'($urandom_range(1, 6));
         run_cmd(a, s, v, $sformatf("rnd%0d", k));
      end
      lo_cycles = 4;

      // Plan item 3: bad selector, then clear
      run_cmd(1'b0, 7, 5, "t3_badsel");
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      tick();
      chk("t3_badsel_cleared", 32'(err_badsel), 32'd0);
      $display("badsel cleared, err_badsel=%0d", err_badsel);

      // Plan item 4: stuck phase_done -> timeout
      pll_stuck = 1'b1;
      exp_updn = 1'b1;
      exp_cntsel = 5'd2;
      b_r = en_rises; b_d = done_cnt;
      send(1'b0, 2, 1);
      wait_done(b_d, "t4");
      tick();
      chk("t4_err_timeout", 32'(err_timeout), 32'd1);
      chk("t4_latency", 32'(to_rise_cyc - last_rise_cyc), 32'(TO));
      chk("t4_one_step", 32'(en_rises - b_r), 32'd1);
      chk("t4_phase_en_low", 32'(phase_en), 32'd0);
      chk("t4_ready", 32'(cmd_if.cmd_ready), 32'd1);
      read_pos(2, "t4_pos_unchanged");
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      tick();
      chk("t4_timeout_cleared", 32'(err_timeout), 32'd0);
      pll_stuck = 1'b0;
      $display("timeout after %0d cycles", to_rise_cyc - last_rise_cyc);

      // Plan item 5: lock loss on the third step of +5
      exp_updn = 1'b1;
      exp_cntsel = 5'd3;
      pos_rd_sel = 3'd3;
      b_r = en_rises; b_d = done_cnt;
      send(1'b0, 3, 5);
      n = 0;
      while ((en_rises - b_r) < 3 && n < 500) begin
         tick();
         n++;
      end
      chk("t5_third_step_reached", 32'(en_rises - b_r), 32'd3);
      chk("t5_pos_before_loss", 32'(pos_rd_data), pos_bits(model_pos[3] + 2));
      pll_locked = 1'b0;
      @(posedge clk);
      #1;
      chk("t5_phase_en_dropped", 32'(phase_en), 32'd0);
      chk("t5_done_pulse", 32'(cmd_if.cmd_done), 32'd1);
      for (int i = 0; i < NUM_CNT; i++) model_pos[i] = 0;
      repeat (3) tick();
      chk("t5_ready_while_unlocked", 32'(cmd_if.cmd_ready), 32'd0);
      chk("t5_no_error", {30'd0, err_timeout, err_badsel}, 32'd0);
      for (int i = 0; i < 8; i++) read_pos(i, $sformatf("t5_pos_cleared%0d", i));
      pll_locked = 1'b1;
      tick();
      chk("t5_ready_relocked", 32'(cmd_if.cmd_ready), 32'd1);
      repeat (10) tick();
      $display("lock loss handled, done pulses=%0d", done_cnt - b_d);

      // Plan item 6: async reset while waiting for phase_done high
      run_cmd(1'b0, 4, 1, "t6_pre");
      pos_rd_sel = 3'd4;
      exp_updn = 1'b1;
      exp_cntsel = 5'd2;
      send(1'b0, 2, 2);
      n = 0;
      while (!(phase_done === 1'b0 && phase_en === 1'b0 && busy === 1'b1) && n < 500) begin
         tick();
         n++;
      end
      chk("t6_in_wait_hi", {30'd0, busy, updn}, 32'd3);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_async_outputs", {24'd0, phase_en, updn, busy, cmd_if.cmd_done, cmd_if.cmd_ready,
                               err_timeout, err_badsel, 1'b0}, 32'd0);
      chk("t6_async_cntsel", 32'(pll_cntsel), 32'd0);
      chk("t6_async_rd", 32'(pos_rd_data), 32'd0);
      for (int i = 0; i < NUM_CNT; i++) model_pos[i] = 0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
      for (int i = 0; i < NUM_CNT; i++) read_pos(i, $sformatf("t6_pos_after_reset%0d", i));
      $display("async reset checked");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
